// File: rtl/xalu_ise_seq.sv
// Rotate-immediate and andn/xorn custom-instruction unit with ready/valid handshake.
// Rotates run in one cycle (ROT_STEP=0) or iterate in steps of at most ROT_STEP bits.
module xalu_ise_seq #(
  parameter int XLEN     = 64,
  parameter int ISE_V    = 1,
  parameter int ROT_STEP = 0
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic [4:0]      ise_fn,
  input  logic [6:0]      ise_imm,
  input  logic [XLEN-1:0] ise_in1,
  input  logic [XLEN-1:0] ise_in2,
  input  logic            ise_val,
  output logic            ise_rdy,
  output logic            ise_oval,
  output logic [XLEN-1:0] ise_out
);

  localparam logic [4:0] STEP = 5'(ROT_STEP);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_cnt;
  logic            r_dir;
  logic            r_w;

  logic [4:0]      w_k;
  logic            w_isRot;
  logic            w_isLogic;
  logic            w_right;
  logic            w_word;
  logic            w_accept;
  logic [4:0]      w_sFirst;
  logic [4:0]      w_sBusy;
  logic [XLEN-1:0] w_firstRot;
  logic [XLEN-1:0] w_busyRot;
  logic [XLEN-1:0] w_logicRes;
  logic            w_unusedFn;

  // Word rotates stay inside the low 32 bits; the upper bits are zero until finalisation.
  function automatic logic [XLEN-1:0] rotate(input logic [XLEN-1:0] x, input logic [4:0] amt,
                                             input logic right, input logic word);
    logic [XLEN-1:0] r;
    logic [31:0]     x32;
    r   = '0;
    x32 = x[31:0];
    if (word)
      r[31:0] = (x32 << amt) | (x32 >> (32 - int'(amt)));
    else if (right)
      r = (x >> amt) | (x << (XLEN - int'(amt)));
    else
      r = (x << amt) | (x >> (XLEN - int'(amt)));
    return r;
  endfunction

  function automatic logic [XLEN-1:0] finalise(input logic [XLEN-1:0] v, input logic word);
    logic [XLEN-1:0] r;
    r = v;
    if (word) begin
      r       = {XLEN{v[31]}};
      r[31:0] = v[31:0];
    end
    return r;
  endfunction

  assign w_k        = ise_imm[4:0];
  assign w_isRot    = (ise_fn[1:0] == 2'b00) && (ise_imm[6:5] != 2'b11);
  assign w_isLogic  = (ise_fn[1:0] == 2'b01) && (ise_imm[6:1] == 6'd0);
  assign w_right    = (ise_imm[6:5] == 2'b10);
  assign w_word     = (ise_imm[6:5] == 2'b01);
  assign w_accept   = (ISE_V != 0) && (r_state == IDLE) && ise_val && (w_isRot || w_isLogic);
  assign w_sFirst   = (ROT_STEP == 0 || w_k <= STEP) ? w_k : STEP;
  assign w_sBusy    = (r_cnt <= STEP) ? r_cnt : STEP;
  assign w_firstRot = rotate(ise_in1, w_sFirst, w_right, w_word);
  assign w_busyRot  = rotate(r_acc, w_sBusy, r_dir, r_w);
  assign w_logicRes = ise_imm[0] ? (ise_in1 ^ ~ise_in2) : (ise_in1 & ~ise_in2);
  assign w_unusedFn = ^ise_fn[4:2];

  assign ise_rdy = (r_state == IDLE);

  // With ROT_STEP=0 the first step covers the whole distance, so every op finalises at accept.
  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      r_state  <= IDLE;
      ise_oval <= 1'b0;
      ise_out  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_w      <= 1'b0;
    end else begin
      ise_oval <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_isLogic) begin
              ise_out  <= w_logicRes;
              ise_oval <= 1'b1;
            end else begin
              r_acc <= w_firstRot;
              r_cnt <= w_k - w_sFirst;
              r_dir <= w_right;
              r_w   <= w_word;
              if (w_k == w_sFirst) begin
                ise_out  <= finalise(w_firstRot, w_word);
                ise_oval <= 1'b1;
              end else begin
                r_state <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          r_acc <= w_busyRot;
          r_cnt <= r_cnt - w_sBusy;
          if (r_cnt == w_sBusy) begin
            ise_out  <= finalise(w_busyRot, r_w);
            ise_oval <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/xalu_ise_seq.md
# xalu_ise_seq

Parametrised, sequential successor of the Xoodyak bit-manipulation ISE unit: executes rotate-immediate and logic custom instructions for an RV32 or RV64 core. Rotates can be either single-cycle or iterative in fixed-size steps to save area. A ready/valid handshake toward the core pipeline is added. The block sits beside the core ALU on the custom-opcode path: it accepts operands when ready and returns one registered result pulse per accepted instruction.

## Interface
- XLEN, 64: datapath width; 32 or 64 only.
- ISE_V, 1: 1 = instructions implemented; 0 = unit inert (never accepts, `ise_rdy`=1, `ise_oval`=0, `ise_out`=0).
- ROT_STEP, 0: 0 = full barrel rotate in one cycle; otherwise maximum rotate distance per cycle; legal values are 1, 2, 4, 8, 16.

Ports:
- ise_clk  in  1  clock; one clock domain.
- ise_rst  in  1  reset, synchronous, active-high.
- ise_fn  in  5  custom opcode selector; bits [1:0] = CUSTOM_0..3.
- ise_imm  in  7  funct field / immediate.
- ise_in1  in  XLEN  rs1.
- ise_in2  in  XLEN  rs2.
- ise_val  in  1  request valid.
- ise_rdy  out  1  unit can accept; high iff state IDLE.
- ise_oval  out  1  result valid, one-cycle pulse, registered.
- ise_out  out  XLEN  result, registered; holds the last result until the next result.

## Operation
- Decode (funct = ise_imm, k = funct[4:0]):
  - roli: fn[1:0]=00, funct[6:5]=00; rotate in1 left by k.
  - roliw: fn[1:0]=00, funct[6:5]=01; rotate in1[31:0] left by k, then sign-extend bit 31 to XLEN. For XLEN=32 it equals roli.
  - rori: fn[1:0]=00, funct[6:5]=10; rotate in1 right by k.
  - andn: fn[1:0]=01, funct=0; in1 & ~in2.
  - xorn: fn[1:0]=01, funct=1; in1 ^ ~in2.
  - Any other encoding is unsupported: it is not accepted, `ise_rdy` stays high and there is no `ise_oval`. The core must not issue it.
- Accept: a request is accepted on a rising edge where state=IDLE, ise_val=1 and the op is supported.
- FSM states: IDLE, BUSY.
- Behaviour on accept, for logic ops or ROT_STEP=0:
  - `ise_out` is loaded with the result.
  - `ise_oval` is set to 1.
  - State stays IDLE.
- Behaviour on accept, for a rotate with ROT_STEP>0:
  - The unit computes s = min(k, ROT_STEP).
  - The accumulator is loaded with in1 (or in1[31:0] for roliw) rotated by s.
  - The remaining count becomes k−s.
  - If the remaining count is 0, the result is finalised immediately: load `ise_out`, set `ise_oval`, stay IDLE. Otherwise go to BUSY.
  - The direction bit and the roliw flag are latched at accept.
- BUSY, each cycle:
  - Rotate the accumulator by s = min(cnt, ROT_STEP) and decrement cnt by s.
  - When cnt reaches 0 on this edge, finalise: roliw sign-extends; load `ise_out`; set `ise_oval`; go to IDLE.
- In ROT_STEP>0 mode, roliw rotates only within the low 32 bits. Its upper bits are ignored until the sign-extension at finalisation.

## Timing
- Reset values: state IDLE, `ise_rdy`=1, `ise_oval`=0, `ise_out`=0, accumulator and count cleared.
- Latency L is counted in cycles from the accept edge T; `ise_oval` is high in cycle T+L.
  - Logic ops, and rotates with ROT_STEP=0: L=1.
  - Iterative rotates: L = max(1, ceil(k/ROT_STEP)); k=0 gives L=1.
- `ise_oval` is high for exactly one cycle per accepted request.
- `ise_rdy` is low for the L−1 BUSY cycles. It is high again in the `ise_oval` cycle, so back-to-back accepts are allowed and give throughput of 1 per cycle for single-cycle ops.
- `ise_val` during BUSY is ignored. The core must hold the request until `ise_rdy`.
- Operands are sampled only at the accept edge; changes on `ise_in1`/`ise_in2`/`ise_imm` while BUSY have no effect.
- Reset asserted in any state takes priority over everything. An in-flight operation is aborted with no `ise_oval`, and all outputs take their reset values on the next edge.

## Test plan
- Reset: hold ise_rst=1 for 2 cycles -> `ise_rdy`=1, `ise_oval`=0, `ise_out`=0; ise_val=1 during reset is not accepted.
- andn with XLEN=64, ROT_STEP=0: in1=0xFFFF0000FFFF0000, in2=0x0F0F0F0F0F0F0F0F, fn=01, imm=0 -> `ise_oval` at T+1, out=0xF0F00000F0F00000. A back-to-back xorn issued at T+1 with in1=0, in2=0 -> out=0xFFFFFFFFFFFFFFFF at T+2.
- roli with ROT_STEP=4: k=5, in1=0x8000000000000001 -> `ise_rdy` low for 1 cycle, `ise_oval` at T+2, out=0x0000000000000030.
- roliw with ROT_STEP=0: k=1, in1=0x12345678C0000000 -> out=0xFFFFFFFF80000001 at T+1. With XLEN=32, in1=0xC0000000 -> out=0x80000001.
- rori with ROT_STEP=2: k=8, in1=0x00000000000000AB -> `ise_oval` at T+4, out=0xAB00000000000000. An andn request presented during BUSY is ignored, then accepted at T+4.
- roli with ROT_STEP=1, k=31: assert reset at T+3 -> no `ise_oval`, `ise_rdy`=1 and out=0 after reset. Then issue fn=10 (unsupported) -> never accepted, `ise_oval` stays 0.
